// File: rtl/gecko_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gecko_stream_ctrl
// Description : Sequencer and byte-stream front-end for the gecko keystream
//               generator. Owns gecko's reset, clken, key and next pins,
//               loads a latched key and buffers one keystream byte at a time.
//               It XORs that byte onto a valid/ready byte stream, so the same
//               path encrypts and decrypts.
//               Optional feature macro: GECKO_AUTOREKEY_EN (automatic rekey
//               after REKEY_BYTES transferred bytes).
// Revision    : 1.0 - initial release
// ============================================================================
module gecko_stream_ctrl #(
    parameter int KEY_LENGTH  = 7,
    parameter int REKEY_BYTES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*KEY_LENGTH-1:0] key_in,
    input  logic                    rekey,
    output logic                    key_req,
    output logic                    busy,
    output logic                    g_rst_n,
    output logic                    g_clken,
    output logic [7:0]              g_key,
    output logic                    g_next,
    input  logic                    g_ready,
    input  logic [7:0]              g_dout,
    input  logic [7:0]              din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [7:0]              dout,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    localparam int             c_ld_w    = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam logic [c_ld_w-1:0] c_ld_last = c_ld_w'(KEY_LENGTH - 1);

    // Parameter range guards, evaluated at elaboration only.
    if (KEY_LENGTH < 1) begin : g_bad_key_length
        $error("gecko_stream_ctrl: KEY_LENGTH must be at least 1");
    end
    if (REKEY_BYTES < 1 || REKEY_BYTES > 65535) begin : g_bad_rekey_bytes
        $error("gecko_stream_ctrl: REKEY_BYTES must be within 1..65535");
    end

    typedef enum logic [1:0] {
        GRST  = 2'd0,
        LOAD  = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [8*KEY_LENGTH-1:0] r_shadow;
    logic [c_ld_w-1:0]       r_ld_cnt;
    logic                    r_g_rst_n;
    logic [7:0]              r_ks;
    logic                    r_ks_valid;
    logic [7:0]              r_dout;
    logic                    r_dout_valid;
    logic                    r_key_req;
    logic                    w_manual;
    logic                    w_auto;
    logic                    w_restart;
    logic                    w_xfer;
    logic                    w_refill;

    // Rekey while already in GRST changes nothing: GRST relatches key_in anyway.
    assign w_manual  = rekey && (r_state != GRST);
    assign w_restart = w_manual || w_auto;

    assign din_ready = (r_state == RUN) && r_ks_valid && (!r_dout_valid || dout_ready);
    assign w_xfer    = din_valid && din_ready;
    // Refill only on an empty buffer so each gecko byte is taken exactly once;
    // a concurrent rekey would discard the byte, so do not consume one.
    assign w_refill  = (r_state == RUN) && !r_ks_valid && g_ready && !rekey;

    assign busy       = (r_state != RUN);
    assign g_rst_n    = r_g_rst_n;
    assign g_clken    = r_g_rst_n;
    assign g_next     = w_refill;
    assign g_key      = (r_state == LOAD) ? r_shadow[7:0] : 8'd0;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign key_req    = r_key_req;

`ifdef GECKO_AUTOREKEY_EN
    logic [15:0] r_count;

    // The transfer that reaches REKEY_BYTES still completes; the restart follows it.
    assign w_auto = w_xfer && (r_count == 16'(REKEY_BYTES - 1));

    // Transferred-byte counter; any restart begins a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'd0;
        end else if (w_manual || w_auto) begin
            r_count <= 16'd0;
        end else if (w_xfer) begin
            r_count <= r_count + 16'd1;
        end
    end

    // One-cycle request so the system can present a fresh key_in during GRST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_req <= 1'b0;
        end else begin
            r_key_req <= w_auto && !w_manual;
        end
    end
`else
    assign w_auto = 1'b0;

    // Without automatic rekey the request output is held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_req <= 1'b0;
        end else begin
            r_key_req <= 1'b0;
        end
    end
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; any restart request overrides the normal flow.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            GRST:    w_state_nxt = LOAD;
            LOAD:    if (r_ld_cnt == c_ld_last) w_state_nxt = PRIME;
            PRIME:   if (g_ready) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = GRST;
        endcase
        if (w_restart) begin
            w_state_nxt = GRST;
        end
    end

    // gecko reset is registered from the next state: low for exactly the GRST cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g_rst_n <= 1'b0;
        end else begin
            r_g_rst_n <= (w_state_nxt != GRST);
        end
    end

    // Key shadow: latched in GRST, shifted one byte per LOAD cycle so byte 0 leads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_ld_cnt <= '0;
        end else if (r_state == GRST) begin
            r_shadow <= key_in;
            r_ld_cnt <= '0;
        end else if (r_state == LOAD) begin
            r_shadow <= r_shadow >> 8;
            r_ld_cnt <= r_ld_cnt + c_ld_w'(1);
        end
    end

    // Single-byte keystream buffer; cleared by use, restart and GRST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ks       <= 8'd0;
            r_ks_valid <= 1'b0;
        end else begin
            if (w_refill) begin
                r_ks       <= g_dout;
                r_ks_valid <= 1'b1;
            end
            if (w_xfer || w_restart || (r_state == GRST)) begin
                r_ks_valid <= 1'b0;
            end
        end
    end

    // Output register: holds data under backpressure, unaffected by rekey.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= 8'd0;
            r_dout_valid <= 1'b0;
        end else if (w_xfer) begin
            r_dout       <= din ^ r_ks;
            r_dout_valid <= 1'b1;
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
